// File: rtl/tick_generator.sv
// Multi-channel tick generator: NUM_CH programmable down-counters, each emitting single-cycle ticks.
// Optional macro TICKGEN_READBACK_EN adds a registered counter readback port (rd_ch / rd_cnt).
module tick_generator #(
    parameter int unsigned       NUM_CH      = 4,
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       DEFAULT_DIV = 100_000,
    parameter logic [NUM_CH-1:0] RESET_EN    = {NUM_CH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    input  logic              cfg_start,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
`ifdef TICKGEN_READBACK_EN
    ,
    input  logic [3:0]        rd_ch,
    output logic [WIDTH-1:0]  rd_cnt
`endif
);

    localparam logic [WIDTH-1:0] DEF_DIV    = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_RELOAD = (DEF_DIV > WIDTH'(1)) ? DEF_DIV - WIDTH'(1) : '0;

    // Divisors 0 and 1 both collapse to a terminal count of zero, i.e. a tick every cycle.
    function automatic logic [WIDTH-1:0] reload(input logic [WIDTH-1:0] d);
        return (d > WIDTH'(1)) ? d - WIDTH'(1) : '0;
    endfunction

    logic [WIDTH-1:0]  div_q [NUM_CH];
    logic [WIDTH-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] os_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                div_q[i] <= DEF_DIV;
                cnt_q[i] <= DEF_RELOAD;
                en_q[i]  <= RESET_EN[i];
                os_q[i]  <= 1'b0;
                tick[i]  <= 1'b0;
            end else if (cfg_we && (int'(cfg_ch) == i)) begin
                // A write discards any pending terminal count, even one due this cycle.
                div_q[i] <= cfg_div;
                cnt_q[i] <= reload(cfg_div);
                en_q[i]  <= cfg_start;
                os_q[i]  <= cfg_oneshot;
                tick[i]  <= 1'b0;
            end else if (pause || !en_q[i]) begin
                tick[i]  <= 1'b0;
            end else if (cnt_q[i] == '0) begin
                tick[i]  <= 1'b1;
                cnt_q[i] <= reload(div_q[i]);
                if (os_q[i]) begin
                    en_q[i] <= 1'b0;
                end
            end else begin
                cnt_q[i] <= cnt_q[i] - WIDTH'(1);
                tick[i]  <= 1'b0;
            end
        end
    end

    assign running = en_q;

`ifdef TICKGEN_READBACK_EN
    logic [WIDTH-1:0] rd_sel;

    // Out-of-range channel numbers fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(rd_ch) == i) begin
                rd_sel = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
        end else begin
            rd_cnt <= rd_sel;
        end
    end
`endif

endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: directed scenarios with literal timing plus a randomized
// run, all checked every cycle against a cycles-until-tick model of each channel.
module tb_tick_generator;

    localparam int          NCH   = 4;
    localparam int          W     = 16;
    localparam int          DDIV  = 5;
    localparam logic [3:0]  RSTEN = 4'b0001;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           pause = 1'b0;
    logic           cfg_we = 1'b0;
    logic [3:0]     cfg_ch = 4'd0;
    logic [W-1:0]   cfg_div = '0;
    logic           cfg_oneshot = 1'b0;
    logic           cfg_start = 1'b0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] running;
`ifdef TICKGEN_READBACK_EN
    logic [3:0]     rd_ch = 4'd0;
    logic [W-1:0]   rd_cnt;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    tick_generator #(
        .NUM_CH(NCH), .WIDTH(W), .DEFAULT_DIV(DDIV), .RESET_EN(RSTEN)
    ) dut (
        .clk(clk), .rst(rst), .pause(pause), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .cfg_start(cfg_start),
        .tick(tick), .running(running)
`ifdef TICKGEN_READBACK_EN
        , .rd_ch(rd_ch), .rd_cnt(rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: each channel counts the active cycles remaining until its next tick.
    int m_per [NCH];
    int m_rem [NCH];
    bit m_en  [NCH];
    bit m_os  [NCH];
    bit m_tick[NCH];

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                m_per[i] = DDIV; m_rem[i] = DDIV; m_en[i] = RSTEN[i]; m_os[i] = 0; m_tick[i] = 0;
            end else if (cfg_we && int'(cfg_ch) == i) begin
                m_per[i] = (int'(cfg_div) < 2) ? 1 : int'(cfg_div);
                m_rem[i] = m_per[i];
                m_en[i] = cfg_start; m_os[i] = cfg_oneshot; m_tick[i] = 0;
            end else if (pause || !m_en[i]) begin
                m_tick[i] = 0;
            end else begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_tick[i] = 1;
                    m_rem[i] = m_per[i];
                    if (m_os[i]) m_en[i] = 0;
                end else begin
                    m_tick[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NCH-1:0] et, er;
            for (int i = 0; i < NCH; i++) begin
                et[i] = m_tick[i];
                er[i] = m_en[i];
            end
            checks++;
            if (tick !== et) begin
                errors++;
                $display("FAIL model_tick t=%0t got=%b exp=%b", $time, tick, et);
            end
            checks++;
            if (running !== er) begin
                errors++;
                $display("FAIL model_running t=%0t got=%b exp=%b", $time, running, er);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the sample point right after the write edge.
    task automatic do_write(input int ch, input int div, input bit os, input bit start);
        cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_div = W'(div); cfg_oneshot = os; cfg_start = start;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_tick", 32'(tick), 32'h0);
        chk("reset_running", 32'(running), 32'h1);
        rst = 1'b0;

        // Reset phase: ch0 ticks at cycles 5, 10, 15
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("rst_tick0", 32'(tick[0]), 32'((k % 5) == 0));
            chk("rst_tick321", 32'(tick[3:1]), 32'h0);
        end

        // One-shot ch1, div 3
        do_write(1, 3, 1'b1, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            chk("os_tick1", 32'(tick[1]), 32'(k == 3));
            chk("os_running1", 32'(running[1]), 32'(k < 3));
        end

        // Pause for 7 cycles two cycles before the tick due at cycle 8
        do_write(0, 4, 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("pause_tick0", 32'(tick[0]), 32'(k == 4 || k == 15 || k == 19));
            if (k == 5) pause = 1'b1;
            if (k == 12) pause = 1'b0;
        end

        // Divisors 0 and 1 tick every cycle; stopping silences the next cycle
        do_write(2, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("div0_tick2", 32'(tick[2]), 32'h1);
        end
        do_write(2, 1, 1'b0, 1'b1);
        chk("div1_write_tick2", 32'(tick[2]), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("div1_tick2", 32'(tick[2]), 32'h1);
        end
        do_write(2, 7, 1'b0, 1'b0);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("stop_tick2", 32'(tick[2]), 32'h0);
            chk("stop_running2", 32'(running[2]), 32'h0);
        end

        // Write landing on the terminal-count cycle suppresses that tick
        do_write(0, 4, 1'b0, 1'b1);
        cyc(3);
        do_write(0, 6, 1'b0, 1'b1);
        chk("tc_write_tick0", 32'(tick[0]), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("tc_newdiv_tick0", 32'(tick[0]), 32'(k == 6));
        end
        do_write(9, 2, 1'b1, 1'b0);
        chk("ch9_running", 32'(running), 32'h1);
        cyc(6);

        // Reset while ch1 is mid-count
        do_write(1, 10, 1'b0, 1'b1);
        cyc(4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tick", 32'(tick), 32'h0);
        chk("midrst_running", 32'(running), 32'h1);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("postrst_tick0", 32'(tick[0]), 32'((k % 5) == 0));
            chk("postrst_tick1", 32'(tick[1]), 32'h0);
`ifdef TICKGEN_READBACK_EN
            if (k == 1) chk("readback_reset", 32'(rd_cnt), 32'(DDIV - 1));
`endif
        end

        // Randomized traffic, including out-of-range channels and occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_ch = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            cfg_div = W'($urandom_range(0, 9));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            cfg_start = ($urandom_range(0, 3) != 0);
            pause = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        rst = 1'b0; cfg_we = 1'b0; pause = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
- Parametrised successor of the fixed three-output clock divider.
- Provides NUM_CH independent tick channels. Each channel has a runtime-programmable divisor, a periodic or one-shot mode, start/stop control and a global pause.
- Feeds the CHIP-8 core (instruction-rate tick, 60 Hz delay/sound ticks) and the VGA pixel strobe.
- Every tick output is a registered, single-cycle pulse in the clk domain.

Parameters:
- NUM_CH, 4, number of tick channels (1..16).
- WIDTH, 32, width of the divisor and counter for each channel.
- DEFAULT_DIV, 100_000, divisor loaded into every channel at reset.
- RESET_EN, {NUM_CH{1'b1}}, per-channel run state at reset; bit i set means channel i runs from reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- pause  input  1  when high, all counters hold and all ticks are 0.
- cfg_we  input  1  configuration write strobe, one cycle.
- cfg_ch  input  4  target channel of the write.
- cfg_div  input  WIDTH  new divisor; tick period equals cfg_div cycles.
- cfg_oneshot  input  1  1 = one-shot mode, 0 = periodic mode.
- cfg_start  input  1  run state written to the channel (1 = run, 0 = stop).
- tick  output  NUM_CH  per-channel tick pulses.
- running  output  NUM_CH  per-channel run state (en_q).

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high, named rst.
- Per-channel state: div_q[WIDTH], cnt_q[WIDTH], en_q, os_q.
- Reload value: R(d) = d-1 when d>=2, else 0. Divisors 0 and 1 both give a tick every cycle.
- Reset values:
  - div_q = DEFAULT_DIV.
  - cnt_q = R(DEFAULT_DIV).
  - en_q = RESET_EN[i].
  - os_q = 0.
  - tick = 0.
  - running = RESET_EN.
- Per-channel update each cycle, highest priority first:
  1. rst: apply the reset values.
  2. cfg_we && cfg_ch==i:
     - div_q<=cfg_div, os_q<=cfg_oneshot, en_q<=cfg_start, cnt_q<=R(cfg_div), tick[i]<=0.
     - Applies even while pause is high. It discards the channel's pending count, so there is no tick in that cycle.
  3. pause or !en_q: cnt_q holds, tick[i]<=0.
  4. cnt_q==0:
     - tick[i]<=1, cnt_q<=R(div_q).
     - If os_q is set, also en_q<=0.
  5. Otherwise: cnt_q<=cnt_q-1, tick[i]<=0.
- Latency and period:
  - After rst deasserts, or after the write cycle, the first tick is high in clock cycle D (counting the first following cycle as 1).
  - Periodic ticks then repeat every D cycles, with no drift.
- Pause:
  - Freezes phase exactly.
  - Pausing for P cycles delays every subsequent tick by P cycles.
  - A tick that would have fired while pause is high fires in the first cycle after pause drops.
- One-shot mode: exactly one tick, then running[i] drops in the same edge that raises the tick. The channel stays idle until rewritten.
- cfg_ch >= NUM_CH: the write is ignored and no state changes.
- Writing a running channel restarts it from R(cfg_div), so its phase restarts. Other channels are unaffected.
- Arithmetic: counters are unsigned WIDTH bits and never wrap below 0. div_q is not modified by counting.
- Channels are fully independent. Simultaneous ticks on several channels are allowed.

Optional Feature:
- Macro: TICKGEN_READBACK_EN.
- Defined:
  - Adds ports rd_ch (input, 4) and rd_cnt (output, WIDTH).
  - rd_cnt is registered: the cycle after rd_ch is presented, rd_cnt = cnt_q[rd_ch] as sampled in that presentation cycle.
  - rd_ch >= NUM_CH returns 0. Reset value of rd_cnt is 0.
- Undefined:
  - The ports are absent and no readback logic is generated.
  - All other behaviour is identical.

Test Plan:
- Reset with DEFAULT_DIV=5, RESET_EN=4'b0001 -> tick[0] high in cycles 5, 10 and 15 after reset release. tick[3:1] stay 0. running=4'b0001.
- Write ch1: div=3, oneshot=1, start=1 -> tick[1] high exactly once, 3 cycles after the write. running[1] falls in the same cycle. No further ticks over 50 cycles.
- ch0 periodic with div=4; assert pause for 7 cycles starting 2 cycles before a due tick -> that tick arrives 7 cycles late. The following period is 4 again.
- Write div=0 and div=1 to ch2 -> tick[2] high every cycle starting 1 cycle after the write. Then write start=0 -> tick[2]=0 from the next cycle.
- Write to ch0 in the same cycle its counter reaches 0 -> no tick in that cycle. The next tick follows the new divisor. A write with cfg_ch=9 changes nothing.
- Assert rst while ch1 is running mid-count -> next cycle: all outputs at reset values and cnt_q reloaded. With READBACK_EN defined, rd_ch=0 then returns DEFAULT_DIV-1 one cycle after reset.
